// File: rtl/ttl_rr_arbiter.sv
// Round-robin arbiter giving one requester at a time a bounded tenure on a shared gate block,
// with a one-cycle all-zero gap between tenures.
//
// state | meaning
// IDLE  | no owner, Grant all zero, waiting for Enable and a request
// GRANT | owner holds the gate block, hold counter running
// GAP   | one break-before-make cycle with Grant all zero, pointer moved past the last owner
module ttl_rr_arbiter #(
  parameter int BLOCKS      = 4,
  parameter int WIDTH_INDEX = 2,
  parameter int HOLD_MAX    = 8,
  parameter int DELAY_RISE  = 0,
  parameter int DELAY_FALL  = 0
) (
  input  logic                   Clk,
  input  logic                   Clear_bar,
  input  logic                   Enable,
  input  logic [BLOCKS-1:0]      Req,
  output logic [BLOCKS-1:0]      Grant,
  output logic [WIDTH_INDEX-1:0] Grant_index,
  output logic                   Busy
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  // Rise/fall delays are zero in silicon; they are only range-checked here.
  if ((2 ** WIDTH_INDEX) < BLOCKS || HOLD_MAX < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
    $error("ttl_rr_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH_INDEX-1:0] owner_q, owner_d;
  logic [WIDTH_INDEX-1:0] ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   req_any;
  logic [WIDTH_INDEX-1:0] sel_idx;

  function automatic logic [WIDTH_INDEX-1:0] wrap_add(input logic [WIDTH_INDEX-1:0] base,
                                                      input int unsigned            off);
    logic [WIDTH_INDEX:0] sum;
    sum = {1'b0, base} + (WIDTH_INDEX + 1)'(off);
    if (sum >= (WIDTH_INDEX + 1)'(BLOCKS)) sum = sum - (WIDTH_INDEX + 1)'(BLOCKS);
    return sum[WIDTH_INDEX-1:0];
  endfunction

  // Descending scan so the requester closest above the pointer wins.
  always_comb begin
    req_any = |Req;
    sel_idx = '0;
    for (int i = BLOCKS - 1; i >= 0; i--) begin
      if (Req[wrap_add(ptr_q, i)]) sel_idx = wrap_add(ptr_q, i);
    end
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= CW'(1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, GAP: begin
        if (Enable && req_any) begin
          state_d = GRANT;
          owner_d = sel_idx;
          cnt_d   = CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (Enable && Req[owner_q] && (cnt_q < CW'(HOLD_MAX))) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = GAP;
          ptr_d   = wrap_add(owner_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only, so Req/Enable never reach them combinationally.
  always_comb begin
    Busy        = (state_q == GRANT);
    Grant       = Busy ? (BLOCKS'(1) << owner_q) : '0;
    Grant_index = Busy ? owner_q : '0;
  end

endmodule

// File: tb/tb_ttl_rr_arbiter.sv
// Vector-table bench for ttl_rr_arbiter (BLOCKS=4, HOLD_MAX=3) with an expected-grant queue
// and a hand-written asynchronous reset sequence.
module tb_ttl_rr_arbiter;

  logic       Clk = 1'b0;
  logic       Clear_bar;
  logic       Enable;
  logic [3:0] Req;
  logic [3:0] Grant;
  logic [1:0] Grant_index;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] exp_grant;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  ttl_rr_arbiter #(
    .BLOCKS(4), .WIDTH_INDEX(2), .HOLD_MAX(3), .DELAY_RISE(0), .DELAY_FALL(0)
  ) dut (
    .Clk(Clk), .Clear_bar(Clear_bar), .Enable(Enable), .Req(Req),
    .Grant(Grant), .Grant_index(Grant_index), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check(input string nm, input logic [3:0] exp_g);
    checks++;
    if (Grant !== exp_g) begin
      errors++;
      $display("FAIL %s grant: got %b want %b", nm, Grant, exp_g);
    end
    checks++;
    if (Busy !== (|exp_g)) begin
      errors++;
      $display("FAIL %s busy: got %b want %b", nm, Busy, |exp_g);
    end
    checks++;
    if (Grant_index !== idx_of(exp_g)) begin
      errors++;
      $display("FAIL %s index: got %0d want %0d", nm, Grant_index, idx_of(exp_g));
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic [3:0] req,
                     input logic [3:0] exp_g, input string nm);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.exp_grant = exp_g; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v);
    logic [3:0] e;
    @(negedge Clk);
    Clear_bar = !v.rst;
    Enable    = v.en;
    Req       = v.req;
    exp_q.push_back(v.exp_grant);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check(v.name, e);
  endtask

  initial begin
    Clear_bar = 1'b0;
    Enable    = 1'b0;
    Req       = 4'b0000;

    // first grant, owner drops, pointer moves on to requester 2
    add(1, 0, 4'b0000, 4'b0000, "r031_rst");
    add(0, 1, 4'b0101, 4'b0001, "r031_g0");
    add(0, 1, 4'b0100, 4'b0000, "r031_gap");
    add(0, 1, 4'b0100, 4'b0100, "r031_g2a");
    add(0, 1, 4'b0100, 4'b0100, "r031_g2b");
    add(0, 1, 4'b0100, 4'b0100, "r031_g2c");
    add(0, 1, 4'b0100, 4'b0000, "r031_hold_gap");
    add(0, 1, 4'b0000, 4'b0000, "r031_idle");

    // all requesting: full rotation with wrap
    add(1, 0, 4'b0000, 4'b0000, "r032_rst");
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) add(0, 1, 4'b1111, 4'(1 << b), "r032_tenure");
      add(0, 1, 4'b1111, 4'b0000, "r032_gap");
    end
    add(0, 1, 4'b1111, 4'b0001, "r032_wrap");

    // lone persistent requester
    add(1, 0, 4'b0000, 4'b0000, "r033_rst");
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 3; k++) add(0, 1, 4'b0010, 4'b0010, "r033_tenure");
      add(0, 1, 4'b0010, 4'b0000, "r033_gap");
    end

    // Enable dropped mid-tenure
    add(1, 0, 4'b0000, 4'b0000, "r034_rst");
    add(0, 1, 4'b0100, 4'b0100, "r034_g2");
    add(0, 0, 4'b0100, 4'b0000, "r034_gap");
    add(0, 0, 4'b0100, 4'b0000, "r034_idle_a");
    add(0, 0, 4'b0100, 4'b0000, "r034_idle_b");
    add(0, 1, 4'b0100, 4'b0100, "r034_regrant");

    // late requester does not preempt
    add(1, 0, 4'b0000, 4'b0000, "r036_rst");
    add(0, 1, 4'b0001, 4'b0001, "r036_g0a");
    add(0, 1, 4'b1001, 4'b0001, "r036_g0b");
    add(0, 1, 4'b1001, 4'b0001, "r036_g0c");
    add(0, 1, 4'b1001, 4'b0000, "r036_gap");
    add(0, 1, 4'b1001, 4'b1000, "r036_g3");

    // requests ignored while disabled in IDLE
    add(1, 0, 4'b0000, 4'b0000, "idle_rst");
    add(0, 0, 4'b0011, 4'b0000, "idle_en0");
    add(0, 1, 4'b0011, 4'b0001, "idle_en1");

    // grant requester 2 ahead of the asynchronous reset sequence
    add(1, 0, 4'b0000, 4'b0000, "r035_rst");
    add(0, 1, 4'b0100, 4'b0100, "r035_g2");

    #1;
    check("reset_state", 4'b0000);

    foreach (vecs[i]) step(vecs[i]);

    // asynchronous reset mid-tenure, away from any clock edge
    #2;
    Clear_bar = 1'b0;
    #1;
    check("r035_async", 4'b0000);
    Req    = 4'b1111;
    Enable = 1'b1;
    @(posedge Clk);
    #1;
    check("r035_held", 4'b0000);
    @(negedge Clk);
    Clear_bar = 1'b1;
    Req       = 4'b1000;
    @(posedge Clk);
    #1;
    check("r035_after", 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttl_rr_arbiter.md
TTL_RR_ARBITER -- requirements
Module: ttl_rr_arbiter

Interface
REQ-001 The block SHALL have parameter BLOCKS, default 4, the number of requesters sharing one gate block.
REQ-002 The block SHALL have parameter WIDTH_INDEX, default 2, the width of Grant_index; it must satisfy 2**WIDTH_INDEX >= BLOCKS.
REQ-003 The block SHALL have parameter HOLD_MAX, default 8, the maximum consecutive grant cycles per tenure; it must be >= 1.
REQ-004 The block SHALL have parameters DELAY_RISE and DELAY_FALL, both default 0, applied to all outputs as rise and fall delays.
REQ-005 The block SHALL have port Clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port Clear_bar  input  1  the asynchronous, active-low reset.
REQ-007 The block SHALL have port Enable  input  1  which, when high, allows new grants and continuation of the current grant.
REQ-008 The block SHALL have port Req  input  BLOCKS  carrying one active-high request per requester.
REQ-009 The block SHALL have port Grant  output  BLOCKS  a one-hot or all-zero grant vector.
REQ-010 The block SHALL have port Grant_index  output  WIDTH_INDEX  giving the binary index of the granted requester.
REQ-011 The block SHALL have port Busy  output  1  which is high exactly when Grant is nonzero.

Function
REQ-012 All outputs SHALL be registered, driven through the DELAY_RISE/DELAY_FALL delay, and free of any combinational path from Req or Enable.
REQ-013 The block SHALL implement a state machine with exactly three states: IDLE, GRANT and GAP.
REQ-014 Internal state SHALL consist of the owner index, a rotation pointer (0..BLOCKS-1) and a hold counter (1..HOLD_MAX).
REQ-015 Selection SHALL pick the first asserted Req bit searching upward from the pointer, wrapping from BLOCKS-1 to 0.
REQ-016 In IDLE, with Enable=1 and Req nonzero at a rising edge, the block SHALL enter GRANT, set owner to the selected index and set the counter to 1, so that Grant is visible one cycle after the request is sampled.
REQ-017 In IDLE, with Enable=0 or Req all zero, the block SHALL stay in IDLE with Grant=0.
REQ-018 In GRANT, the block SHALL hold owner and increment the counter while Enable=1, Req[owner]=1 and counter < HOLD_MAX.
REQ-019 In GRANT, the block SHALL enter GAP when Req[owner]=0, Enable=0 or counter = HOLD_MAX; the transition is break-before-make.
REQ-020 On entry to GAP, the pointer SHALL be set to (owner+1) mod BLOCKS.
REQ-021 In GAP, Grant SHALL be all zero for exactly one cycle.
REQ-022 From GAP, the block SHALL apply the IDLE decision of REQ-016/REQ-017 using the updated pointer.
REQ-023 A lone persistent requester SHALL be re-granted after each one-cycle gap; any other pending requester SHALL win the next tenure before it.
REQ-024 Grant_index SHALL equal owner while Busy=1 and 0 otherwise; Grant SHALL equal 1<<owner while Busy=1.
REQ-025 Requests from other requesters arriving during GRANT SHALL NOT preempt the owner.
REQ-026 Req bits at positions >= BLOCKS SHALL NOT exist; the selection search SHALL never produce an index >= BLOCKS.

Reset
REQ-027 Clear_bar=0 SHALL immediately, with no clock required, force IDLE, Grant=0, Grant_index=0, Busy=0, pointer=0 and counter=1.
REQ-028 A reset asserted during GRANT SHALL drop Grant asynchronously and discard the tenure.
REQ-029 After reset release, the first grant SHALL follow REQ-016 starting from pointer 0.
REQ-030 While Clear_bar=0, rising Clk edges SHALL have no effect.

Verification (BLOCKS=4, HOLD_MAX=3)
REQ-031 Reset, then Req=0101, Enable=1 -> Grant=0001 one cycle later; Req[0] dropped -> GAP cycle with Grant=0000, then Grant=0100, Grant_index=2.
REQ-032 Req=1111 held steady -> Grant sequence 0001 x3, 0000, 0010 x3, 0000, 0100 x3, 0000, 1000 x3, 0000, 0001 (wrap).
REQ-033 Req=0010 held alone -> Grant 0010 x3, 0000, 0010 x3, repeating; Busy follows Grant.
REQ-034 During Grant=0100, drop Enable -> next cycle Grant=0000 (GAP), then IDLE while Enable=0 even though Req is nonzero.
REQ-035 Assert Clear_bar=0 mid-tenure between clock edges -> Grant=0000, Busy=0, Grant_index=0 without a clock; after release with Req=1000 -> Grant=1000 one cycle later.
REQ-036 With Req=0001 and Req[3] raised during the tenure -> owner 0 keeps its full 3 cycles, then GAP, then Grant=1000.
